// File: rtl/div_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor.
// The state encodings are fixed so they can be matched against logic-analyser captures.
package div_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int MATCH_W = 4;

endpackage

// File: rtl/div_monitor_if.sv
// Bundle carrying the waveform under test and the monitor's status outputs.
// master drives the waveform and observes the status; slave is the monitor itself.
interface div_monitor_if #(
    parameter int WIDTH = 8
);
    logic             sig_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             period_valid;
    logic [WIDTH-1:0] half_period;
    logic             locked;
    logic             overflow;

    modport master (
        output sig_in,
        input  rise_pulse, fall_pulse, period_valid, half_period, locked, overflow
    );

    modport slave (
        input  sig_in,
        output rise_pulse, fall_pulse, period_valid, half_period, locked, overflow
    );
endinterface

// File: rtl/div_monitor_sync_edge_detect.sv
// Three-flop synchronizer for the asynchronous waveform with edge strobes
// decoded from the two settled stages, so the strobes depend on flops only.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/div_monitor.sv
// Measures the half-period of a synchronized divided clock and declares lock once
// LOCK_COUNT consecutive measurements equal EXPECT_HALF. EXPECT_HALF must be at least 2.
module div_monitor
    import div_monitor_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EXPECT_HALF = 7,
    parameter int LOCK_COUNT  = 3
) (
    input  logic         clk,
    input  logic         reset,
    div_monitor_if.slave mon
);
    localparam logic [WIDTH-1:0]   CNT_MAX = '1;
    localparam logic [WIDTH-1:0]   EXPECT  = WIDTH'(EXPECT_HALF);
    localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_COUNT);

    logic rise, fall, edgeSeen;

    sync_edge_detect uSync (
        .clk   (clk),
        .reset (reset),
        .d     (mon.sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign edgeSeen = rise | fall;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [MATCH_W-1:0]   matchCnt_q, matchCnt_d;
    logic [WIDTH-1:0]     halfPeriod_q, halfPeriod_d;
    logic                 periodValid_q, periodValid_d;
    logic                 locked_q, locked_d;
    logic                 overflow_q, overflow_d;
    logic                 risePulse_q, fallPulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            matchCnt_q    <= '0;
            halfPeriod_q  <= '0;
            periodValid_q <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
            risePulse_q   <= 1'b0;
            fallPulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            matchCnt_q    <= matchCnt_d;
            halfPeriod_q  <= halfPeriod_d;
            periodValid_q <= periodValid_d;
            locked_q      <= locked_d;
            overflow_q    <= overflow_d;
            risePulse_q   <= rise;
            fallPulse_q   <= fall;
        end
    end

    // cnt restarts at 1 on an edge so that at the following edge it equals the distance.
    // An edge always beats saturation: a 2^WIDTH-1 distance is still a valid measurement.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WIDTH'(1);
        matchCnt_d    = matchCnt_q;
        halfPeriod_d  = halfPeriod_q;
        periodValid_d = 1'b0;
        locked_d      = locked_q;
        overflow_d    = overflow_q;

        if (edgeSeen) begin
            cnt_d = WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (edgeSeen) begin
                    state_d    = MEASURE;
                    overflow_d = 1'b0;
                end
            end
            MEASURE, LOCKED: begin
                if (edgeSeen) begin
                    periodValid_d = 1'b1;
                    halfPeriod_d  = cnt_q;
                    if (cnt_q != EXPECT) begin
                        matchCnt_d = '0;
                        locked_d   = 1'b0;
                        state_d    = MEASURE;
                    end else if (state_q == MEASURE) begin
                        if (matchCnt_q + MATCH_W'(1) >= LOCK_N) begin
                            matchCnt_d = LOCK_N;
                            locked_d   = 1'b1;
                            state_d    = LOCKED;
                        end else begin
                            matchCnt_d = matchCnt_q + MATCH_W'(1);
                        end
                    end
                end else if (cnt_q == CNT_MAX) begin
                    overflow_d = 1'b1;
                    locked_d   = 1'b0;
                    matchCnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mon.rise_pulse   = risePulse_q;
    assign mon.fall_pulse   = fallPulse_q;
    assign mon.period_valid = periodValid_q;
    assign mon.half_period  = halfPeriod_q;
    assign mon.locked       = locked_q;
    assign mon.overflow     = overflow_q;
endmodule
